// File: rtl/seven_seg_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment digit bus between NUM_REQ requesters.
// Each grant is held for a minimum time before another requester can take over.
module seven_seg_display_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int NUM_SEGMENTS = 4,
   parameter int CLK_PER      = 10,
   parameter int HOLD_US      = 500000
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [NUM_REQ-1:0]                        req,
   input  logic [NUM_REQ-1:0][NUM_SEGMENTS-1:0][3:0] req_digits,
   output logic [NUM_REQ-1:0]                        grant,
   output logic [$clog2(NUM_REQ)-1:0]                owner_id,
   output logic [NUM_SEGMENTS-1:0][3:0]              encoded,
   output logic                                      blank,
   output logic                                      switch_pulse
);

   localparam int HOLD_CYCLES = HOLD_US * 1000 / CLK_PER;
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(HOLD_CYCLES);
   localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
   localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic {IDLE, OWN} state_t;

   state_t            state;
   logic [CW-1:0]     hold_cnt;
   logic [NUM_REQ-1:0] others;
   logic [IW-1:0]     pick;

   // First set bit of mask at or after last+1, wrapping modulo NUM_REQ.
   function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] last,
                                             input logic [NUM_REQ-1:0] mask);
      logic [IW-1:0] result;
      logic          found;
      int            idx;
      result = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(last) + 1 + k) % NUM_REQ;
         if (!found && mask[idx]) begin
            result = IW'(idx);
            found  = 1'b1;
         end
      end
      return result;
   endfunction

   // grant is zero in IDLE, so this is simply req there; in OWN it excludes the owner.
   assign others = req & ~grant;
   assign pick   = rr_pick(owner_id, others);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         grant        <= '0;
         owner_id     <= IW'(NUM_REQ - 1);
         encoded      <= '0;
         blank        <= 1'b1;
         switch_pulse <= 1'b0;
         hold_cnt     <= '0;
      end else begin
         switch_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  state        <= OWN;
                  owner_id     <= pick;
                  grant        <= ONE << pick;
                  encoded      <= req_digits[pick];
                  blank        <= 1'b0;
                  switch_pulse <= 1'b1;
                  hold_cnt     <= '0;
               end else begin
                  grant   <= '0;
                  blank   <= 1'b1;
                  encoded <= '0;
               end
            end
            OWN: begin
               if (!req[owner_id] || (hold_cnt == HOLD_MAX && |others)) begin
                  if (|others) begin
                     owner_id     <= pick;
                     grant        <= ONE << pick;
                     encoded      <= req_digits[pick];
                     switch_pulse <= 1'b1;
                     hold_cnt     <= '0;
                  end else begin
                     state    <= IDLE;
                     grant    <= '0;
                     blank    <= 1'b1;
                     encoded  <= '0;
                     hold_cnt <= '0;
                  end
               end else begin
                  encoded <= req_digits[owner_id];
                  if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed bench for seven_seg_display_arbiter with a 100-cycle hold (HOLD_US=1, CLK_PER=10).
module tb_seven_seg_display_arbiter;

   logic                  clk;
   logic                  rst_n;
   logic [2:0]            req;
   logic [2:0][3:0][3:0]  req_digits;
   logic [2:0]            grant;
   logic [1:0]            owner_id;
   logic [3:0][3:0]       encoded;
   logic                  blank;
   logic                  switch_pulse;

   int errors = 0;
   int checks = 0;

   seven_seg_display_arbiter #(
      .NUM_REQ(3), .NUM_SEGMENTS(4), .CLK_PER(10), .HOLD_US(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_digits(req_digits),
      .grant(grant), .owner_id(owner_id), .encoded(encoded),
      .blank(blank), .switch_pulse(switch_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Stays with grant g and no pulse for n more edges.
   task automatic hold_for(input string tag, input logic [2:0] g, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_grant"}, 32'(grant), 32'(g));
         chk({tag, "_pulse"}, 32'(switch_pulse), 32'd0);
      end
   endtask

   task automatic chk_switch(input string tag, input logic [2:0] g, input logic [1:0] id,
                             input logic [15:0] digits);
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_owner"}, 32'(owner_id), 32'(id));
      chk({tag, "_pulse"}, 32'(switch_pulse), 32'd1);
      chk({tag, "_enc"}, 32'(encoded), 32'(digits));
      chk({tag, "_blank"}, 32'(blank), 32'd0);
      chk({tag, "_hold"}, 32'(dut.hold_cnt), 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_blank"}, 32'(blank), 32'd1);
      chk({tag, "_enc"}, 32'(encoded), 32'd0);
      chk({tag, "_owner"}, 32'(owner_id), 32'd2);
      chk({tag, "_pulse"}, 32'(switch_pulse), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 3'b111;
      req_digits[0] = 16'h0A0B;
      req_digits[1] = 16'h1234;
      req_digits[2] = 16'hC0DE;

      // Reset held 3 cycles with all requests high.
      tick(); tick(); tick();
      chk_reset("rst");
      chk("rst_hold", 32'(dut.hold_cnt), 32'd0);

      // Release: requester 0 wins first, then full rotation.
      rst_n = 1'b1;
      tick();
      chk_switch("rel", 3'b001, 2'd0, 16'h0A0B);
      hold_for("rot0", 3'b001, 99);
      tick();
      chk_switch("rot1", 3'b010, 2'd1, 16'h1234);
      hold_for("rot1h", 3'b010, 99);
      tick();
      chk_switch("rot2", 3'b100, 2'd2, 16'hC0DE);
      hold_for("rot2h", 3'b100, 99);
      tick();
      chk_switch("rot3", 3'b001, 2'd0, 16'h0A0B);

      // Reset mid-hold, then a full hold restarts from requester 0.
      for (int i = 0; i < 50; i++) tick();
      chk("mid_hold", 32'(dut.hold_cnt), 32'd50);
      rst_n = 1'b0;
      tick();
      chk_reset("midrst");
      rst_n = 1'b1;
      tick();
      chk_switch("rerel", 3'b001, 2'd0, 16'h0A0B);
      hold_for("rerelh", 3'b001, 99);
      tick();
      chk_switch("rerot", 3'b010, 2'd1, 16'h1234);

      // Owner 1 drops while 0 requests: immediate switch, then build hold_cnt=10.
      req = 3'b001;
      tick();
      chk_switch("drop1", 3'b001, 2'd0, 16'h0A0B);
      hold_for("drop1h", 3'b001, 10);
      chk("hold10", 32'(dut.hold_cnt), 32'd10);
      req = 3'b100;
      tick();
      chk_switch("early", 3'b100, 2'd2, 16'hC0DE);

      // Everyone drops: idle, owner_id remembers 2.
      req = 3'b000;
      tick();
      chk_reset("idle");
      tick();
      chk_reset("idle2");
      req = 3'b101;
      tick();
      chk_switch("rereq", 3'b001, 2'd0, 16'h0A0B);

      // Lone owner 1 keeps display for 1000 cycles.
      req = 3'b010;
      tick();
      chk_switch("lone", 3'b010, 2'd1, 16'h1234);
      hold_for("loneh", 3'b010, 1000);
      chk("sat", 32'(dut.hold_cnt), 32'd99);
      chk("lone_enc", 32'(encoded), 32'h1234);
      req_digits[1] = 16'h5678;
      tick();
      chk("live_enc", 32'(encoded), 32'h5678);
      chk("live_pulse", 32'(switch_pulse), 32'd0);

      // New request after saturation takes over on the next edge.
      req = 3'b011;
      tick();
      chk_switch("late", 3'b001, 2'd0, 16'h0A0B);
      hold_for("lateh", 3'b001, 5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seven_seg_display_arbiter.md
Name: seven_seg_display_arbiter

Overview:
- Shares one multi-digit seven-segment display between NUM_REQ requesters (e.g. score, timer, status).
- Grants the display round-robin with a minimum ownership time, so a digit set stays readable before it is pre-empted.
- Drives the digit bus that feeds seven_seg_controller's encoded input.
- Provides a blank flag so top level can gate the anodes when no one owns the display.

Parameters:
- NUM_REQ, 3, number of requesters; must be at least 2.
- NUM_SEGMENTS, 4, digits per requester; matches the display controller.
- CLK_PER, 10, clock period in ns.
- HOLD_US, 500000, minimum ownership time in microseconds.
- HOLD_CYCLES (localparam) = HOLD_US*1000/CLK_PER; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  NUM_REQ  request level per requester, held high while it wants the display.
- req_digits  in  [NUM_REQ][NUM_SEGMENTS][4]  BCD/hex digits per requester.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- owner_id  out  $clog2(NUM_REQ)  index of current or last owner.
- encoded  out  [NUM_SEGMENTS][4]  digits to the display controller.
- blank  out  1  high when no owner.
- switch_pulse  out  1  one-cycle strobe on every ownership change, including idle to owner.

Behaviour:
- All outputs are registered.
- Reset (rst_n low at a clk edge) takes priority over everything, including mid-hold. Reset values:
  - state=IDLE, grant=0, owner_id=NUM_REQ-1, encoded=0, blank=1, switch_pulse=0, hold_cnt=0.
  - owner_id=NUM_REQ-1 means requester 0 wins first.
- Round-robin search RR(start): lowest index i at or after start (mod NUM_REQ) with req[i]=1.
- State IDLE:
  - If any req is high at an edge: state becomes OWN, owner_id=RR(owner_id+1), grant becomes one-hot of owner_id, encoded=req_digits[new owner].
  - On that same edge: blank=0, switch_pulse=1, hold_cnt=0.
  - Latency from req rising to grant is 1 cycle.
  - Otherwise stay in IDLE: grant=0, blank=1, encoded=0.
- State OWN, evaluated every edge in this priority order:
  1. Owner drops req:
     - If any other req is high, switch immediately to RR(owner+1): grant and owner_id update, hold_cnt=0, switch_pulse=1.
     - Otherwise go to IDLE: grant=0, blank=1, encoded=0, switch_pulse=0. owner_id keeps the last owner.
  2. hold_cnt==HOLD_CYCLES-1 and another requester is high: switch to RR(owner+1), excluding the owner; hold_cnt=0, switch_pulse=1.
  3. Otherwise stay with the current owner:
     - hold_cnt increments, saturating at HOLD_CYCLES-1.
     - A lone owner therefore keeps the display indefinitely.
     - A new request arriving after saturation takes over on the next edge.
- Live digits: while in OWN, encoded <= req_digits[grant target of this edge] every cycle. A digit change by the owner appears on encoded 1 cycle later.
- On a switch, encoded shows the new owner's digits on the same edge that grant changes. No blank cycle is inserted between owners.
- switch_pulse is high for exactly one cycle per change and is 0 otherwise.
- grant is always one-hot or zero.
- hold_cnt width is $clog2(HOLD_CYCLES) and it never wraps.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with req=3'b111. Required: grant=000, blank=1, encoded=16'h0000. Release rst_n, and 1 cycle later: grant=001, switch_pulse=1, owner_id=0.
2. Single requester, lone owner: req=3'b010, req_digits[1]=16'h1234. Required: 1 cycle later grant=010, encoded=16'h1234, blank=0; grant=010 for 1000 cycles. Then change req_digits[1] to 16'h5678: encoded=16'h5678 exactly 1 cycle later.
3. Contention rotation: HOLD_US=1, CLK_PER=10 (100 cycles), req=3'b111 from reset release. Required: grant is 001 for 100 cycles, then 010 for 100, then 100 for 100, then 001. switch_pulse fires at each boundary.
4. Owner drop, early switch: grant=001 and hold_cnt=10, then req goes 001→100. Required: next edge grant=100, encoded=req_digits[2], switch_pulse=1, hold_cnt=0.
5. All drop, then re-request: with owner 2, req→000. Required: next edge grant=000, blank=1, encoded=0. Then req=3'b101: grant=001, since the search starts at owner_id+1 = 0.
6. Reset mid-hold: during test 3 at hold_cnt=50, pulse rst_n low for 1 cycle. Required: outputs at reset values next edge. After release, grant=001 and a full 100-cycle hold restarts.
